alarm_sequencer: RTL and testbench

Downstream consumer of the main controller's `timer_done` in the egg timer. When the countdown reaches 00:00 with the timer enabled, it runs a cadenced alarm:
- an audible square-wave tone in bursts of beeps;
- an alarm LED;
- a display-blank strobe that flashes the seven-segment digits in step with the beeps.

The alarm stops on acknowledge, on disable, or on an optional timeout. It runs on `clk_5MHz` and uses the 10 ms clock-enable pulse as its cadence tick.

---
 rtl/eggtimer_pkg.sv | 31 +++
 rtl/alarm_sequencer_tone_gen.sv | 31 +++
 rtl/alarm_sequencer.sv | 178 +++++++++++++++++
 tb/tb_alarm_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/eggtimer_pkg.sv
// Shared egg-timer definitions: alarm FSM state encodings, default cadence
// constants and a counter-width helper.
package eggtimer_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_BEEP     = 3'd1;
  localparam logic [2:0] ST_GAP      = 3'd2;
  localparam logic [2:0] ST_PAUSE    = 3'd3;
  localparam logic [2:0] ST_SILENCED = 3'd4;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    BEEP     = ST_BEEP,
    GAP      = ST_GAP,
    PAUSE    = ST_PAUSE,
    SILENCED = ST_SILENCED
  } alarm_state_t;

  localparam int unsigned DEF_TONE_HALF      = 1250;
  localparam int unsigned DEF_BEEP_TICKS     = 25;
  localparam int unsigned DEF_GAP_TICKS      = 25;
  localparam int unsigned DEF_BEEPS          = 4;
  localparam int unsigned DEF_PAUSE_TICKS    = 100;
  localparam int unsigned DEF_TIMEOUT_BURSTS = 30;

  // Bits for a counter running 0..max_val-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/alarm_sequencer_tone_gen.sv
// Square-wave tone source: toggles every HALF_PERIOD enabled cycles and
// holds counter and output low whenever enable is low.
module tone_gen
  import eggtimer_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = DEF_TONE_HALF
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tone
);

  localparam int unsigned CW = cnt_width(HALF_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset || !enable) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tone <= ~tone;
    end else begin
      cnt  <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/alarm_sequencer.sv
// Cadenced egg-timer alarm: beep bursts, LED and display blanking after the
// countdown ends. Define ALARM_TIMEOUT_EN to auto-silence after TIMEOUT_BURSTS.
module alarm_sequencer
  import eggtimer_pkg::*;
#(
  parameter int unsigned TONE_HALF      = DEF_TONE_HALF,
  parameter int unsigned BEEP_TICKS     = DEF_BEEP_TICKS,
  parameter int unsigned GAP_TICKS      = DEF_GAP_TICKS,
  parameter int unsigned BEEPS          = DEF_BEEPS,
  parameter int unsigned PAUSE_TICKS    = DEF_PAUSE_TICKS,
  parameter int unsigned TIMEOUT_BURSTS = DEF_TIMEOUT_BURSTS
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic timer_done,
  input  logic timer_en,
  input  logic ack,
  output logic buzzer,
  output logic alarm_led,
  output logic display_blank,
  output logic alarm_active
);

  if (TONE_HALF == 0 || BEEP_TICKS == 0 || GAP_TICKS == 0 || BEEPS == 0 ||
      PAUSE_TICKS == 0 || TIMEOUT_BURSTS == 0) begin : g_bad_cfg
    $error("alarm_sequencer: cadence parameters must be non-zero");
  end

  localparam int unsigned TICK_MAX_BG = (BEEP_TICKS > GAP_TICKS) ? BEEP_TICKS : GAP_TICKS;
  localparam int unsigned TICK_MAX    = (TICK_MAX_BG > PAUSE_TICKS) ? TICK_MAX_BG : PAUSE_TICKS;
  localparam int unsigned TICK_W      = cnt_width(TICK_MAX);
  localparam int unsigned BEEP_W      = cnt_width(BEEPS);

  localparam logic [TICK_W-1:0] BEEP_LAST  = TICK_W'(BEEP_TICKS - 1);
  localparam logic [TICK_W-1:0] GAP_LAST   = TICK_W'(GAP_TICKS - 1);
  localparam logic [TICK_W-1:0] PAUSE_LAST = TICK_W'(PAUSE_TICKS - 1);
  localparam logic [BEEP_W-1:0] BEEPS_LAST = BEEP_W'(BEEPS - 1);

  alarm_state_t state, next_state;
  logic [TICK_W-1:0] tick_cnt, tick_nxt;
  logic [BEEP_W-1:0] beep_cnt, beep_nxt;
  logic              done_q, ack_q;
  logic              done_rise_c, abort_c, tone_en_c, active_nxt, blank_nxt;

`ifdef ALARM_TIMEOUT_EN
  localparam int unsigned BURST_W = cnt_width(TIMEOUT_BURSTS);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(TIMEOUT_BURSTS - 1);
  logic [BURST_W-1:0] burst_cnt, burst_nxt;
`endif

  assign done_rise_c = timer_done & ~done_q;
  assign abort_c     = (ack & ~ack_q) | ~timer_en;
  // Tone stops at the same edge BEEP is left, so buzzer is low outside BEEP.
  assign tone_en_c   = (state == BEEP) && (next_state == BEEP);
  assign active_nxt  = (next_state == BEEP) || (next_state == GAP) || (next_state == PAUSE);
  assign blank_nxt   = (next_state == GAP) || (next_state == PAUSE);

  // done_q resets high so a level already present at reset release is not an edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      beep_cnt      <= '0;
      done_q        <= 1'b1;
      ack_q         <= 1'b0;
      alarm_active  <= 1'b0;
      alarm_led     <= 1'b0;
      display_blank <= 1'b0;
`ifdef ALARM_TIMEOUT_EN
      burst_cnt     <= '0;
`endif
    end else begin
      state         <= next_state;
      tick_cnt      <= tick_nxt;
      beep_cnt      <= beep_nxt;
      done_q        <= timer_done;
      ack_q         <= ack;
      alarm_active  <= active_nxt;
      alarm_led     <= active_nxt;
      display_blank <= blank_nxt;
`ifdef ALARM_TIMEOUT_EN
      burst_cnt     <= burst_nxt;
`endif
    end
  end

  // Cadence FSM; abort outranks every tick-driven transition.
  always_comb begin
    next_state = state;
    tick_nxt   = tick_cnt;
    beep_nxt   = beep_cnt;
`ifdef ALARM_TIMEOUT_EN
    burst_nxt  = burst_cnt;
`endif
    case (state)
      IDLE: begin
        if (done_rise_c && timer_en) begin
          next_state = BEEP;
          tick_nxt   = '0;
          beep_nxt   = '0;
`ifdef ALARM_TIMEOUT_EN
          burst_nxt  = '0;
`endif
        end
      end
      BEEP: begin
        if (abort_c) begin
          next_state = SILENCED;
        end else if (tick) begin
          if (tick_cnt == BEEP_LAST) begin
            tick_nxt = '0;
            if (beep_cnt == BEEPS_LAST) begin
              beep_nxt   = '0;
              next_state = PAUSE;
            end else begin
              beep_nxt   = beep_cnt + BEEP_W'(1);
              next_state = GAP;
            end
          end else begin
            tick_nxt = tick_cnt + TICK_W'(1);
          end
        end
      end
      GAP: begin
        if (abort_c) begin
          next_state = SILENCED;
        end else if (tick) begin
          if (tick_cnt == GAP_LAST) begin
            tick_nxt   = '0;
            next_state = BEEP;
          end else begin
            tick_nxt = tick_cnt + TICK_W'(1);
          end
        end
      end
      PAUSE: begin
        if (abort_c) begin
          next_state = SILENCED;
        end else if (tick) begin
          if (tick_cnt == PAUSE_LAST) begin
            tick_nxt = '0;
`ifdef ALARM_TIMEOUT_EN
            if (burst_cnt == BURST_LAST) begin
              next_state = SILENCED;
            end else begin
              burst_nxt  = burst_cnt + BURST_W'(1);
              next_state = BEEP;
            end
`else
            next_state = BEEP;
`endif
          end else begin
            tick_nxt = tick_cnt + TICK_W'(1);
          end
        end
      end
      SILENCED: begin
        if (!timer_done) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  tone_gen #(
    .HALF_PERIOD(TONE_HALF)
  ) u_tone_gen (
    .clk   (clk),
    .reset (reset),
    .enable(tone_en_c),
    .tone  (buzzer)
  );

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer with a shortened cadence and a tick
// every 10 clocks; expected output patterns are hand-derived edge counts.
module tb_alarm_sequencer;

  localparam logic [3:0] O_IDLE    = 4'b0000;  // {active, led, blank, buzzer}
  localparam logic [3:0] O_BEEP_LO = 4'b1100;
  localparam logic [3:0] O_BEEP_HI = 4'b1101;
  localparam logic [3:0] O_QUIET   = 4'b1110;

  logic clk;
  logic reset, tick, timer_done, timer_en, ack;
  logic buzzer, alarm_led, display_blank, alarm_active;
  logic [3:0] outs;

  int unsigned cyc;
  int unsigned n_checks;
  int unsigned n_fails;
  int unsigned buzz;
  int unsigned bad;

  assign outs = {alarm_active, alarm_led, display_blank, buzzer};

  alarm_sequencer #(
    .TONE_HALF     (4),
    .BEEP_TICKS    (3),
    .GAP_TICKS     (2),
    .BEEPS         (2),
    .PAUSE_TICKS   (5),
    .TIMEOUT_BURSTS(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .timer_done   (timer_done),
    .timer_en     (timer_en),
    .ack          (ack),
    .buzzer       (buzzer),
    .alarm_led    (alarm_led),
    .display_blank(display_blank),
    .alarm_active (alarm_active)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock; tick is high for every tenth edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    tick = (((cyc + 1) % 10) == 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Raise timer_done so the sampling edge is also a tick edge; returns at k=0.
  task automatic trigger();
    step();
    while (((cyc + 1) % 10) != 0) step();
    timer_done = 1'b1;
    step();
  endtask

  initial begin
    reset = 1'b0; tick = 1'b0; timer_done = 1'b0; timer_en = 1'b1; ack = 1'b0;
    cyc = 0; n_checks = 0; n_fails = 0;

    run(3);
    check("reset_outs", 32'(outs), 32'(O_IDLE));
    reset = 1'b1;
    run(2);
    check("idle_quiet", 32'(outs), 32'(O_IDLE));

    // Full cadence: beep 30 clks, gap 20, beep 30, pause 50 per burst.
    trigger();
    check("beep1_entry", 32'(outs), 32'(O_BEEP_LO));
    buzz = 0; bad = 0;
    for (int k = 1; k < 30; k++) begin
      step();
      if (buzzer) buzz++;
      if (outs[3:1] != 3'b110) bad++;
      if (k == 3) check("tone_pre_rise", 32'(buzzer), 32'd0);
      if (k == 4) check("tone_first_rise", 32'(buzzer), 32'd1);
    end
    check("beep1_shape_errs", bad, 32'd0);
    check("beep1_buzz_cycles", buzz, 32'd14);
    step();     check("gap1_start", 32'(outs), 32'(O_QUIET));
    run(19);    check("gap1_end", 32'(outs), 32'(O_QUIET));
    step();     check("beep2_start", 32'(outs), 32'(O_BEEP_LO));
    run(29);    check("beep2_end", 32'(outs), 32'(O_BEEP_HI));
    step();     check("pause1_start", 32'(outs), 32'(O_QUIET));
    run(49);    check("pause1_end", 32'(outs), 32'(O_QUIET));
    step();     check("burst2_start", 32'(outs), 32'(O_BEEP_LO));
    run(129);   check("pause2_end", 32'(outs), 32'(O_QUIET));
    step();
`ifdef ALARM_TIMEOUT_EN
    check("timeout_silence", 32'(outs), 32'(O_IDLE));
    run(40);
    check("timeout_hold", 32'(outs), 32'(O_IDLE));
`else
    check("burst3_start", 32'(outs), 32'(O_BEEP_LO));
    timer_en = 1'b0;
    step();
    check("disable_in_beep", 32'(outs), 32'(O_IDLE));
`endif
    timer_done = 1'b0;
    run(2);
    timer_en = 1'b1;

    // Ack during second beep, then hold silenced while timer_done stays high.
    trigger();
    run(60);
    ack = 1'b1;
    step();
    check("ack_beep2", 32'(outs), 32'(O_IDLE));
    run(5);
    ack = 1'b0;
    run(50);
    check("silenced_hold", 32'(outs), 32'(O_IDLE));
    timer_done = 1'b0;
    run(2);
    timer_done = 1'b1;
    step();
    check("fresh_retrigger", 32'(outs), 32'(O_BEEP_LO));
    timer_en = 1'b0;
    step();
    check("disable_abort", 32'(outs), 32'(O_IDLE));
    timer_done = 1'b0;
    run(2);
    timer_en = 1'b1;

    // Rising edge while disabled is ignored, also after enabling later.
    timer_en = 1'b0;
    timer_done = 1'b1;
    run(5);
    check("en_low_ignore", 32'(outs), 32'(O_IDLE));
    timer_en = 1'b1;
    run(20);
    check("en_late_no_alarm", 32'(outs), 32'(O_IDLE));
    timer_done = 1'b0;
    run(2);

    // Ack on the same edge as the BEEP->GAP tick wins.
    trigger();
    run(29);
    check("pre_gap_beep", 32'(outs), 32'(O_BEEP_HI));
    ack = 1'b1;
    step();
    check("ack_beats_gap", 32'(outs), 32'(O_IDLE));
    ack = 1'b0;
    timer_done = 1'b0;
    run(2);
    check("back_idle", 32'(outs), 32'(O_IDLE));

    // Disable mid-pause.
    trigger();
    run(100);
    check("mid_pause", 32'(outs), 32'(O_QUIET));
    timer_en = 1'b0;
    step();
    check("en_fall_pause", 32'(outs), 32'(O_IDLE));
    timer_done = 1'b0;
    run(2);
    timer_en = 1'b1;

    // Reset while the buzzer is high; held timer_done must not re-arm.
    trigger();
    run(5);
    check("pre_reset_buzz", 32'(outs), 32'(O_BEEP_HI));
    reset = 1'b0;
    step();
    check("reset_mid_beep", 32'(outs), 32'(O_IDLE));
    reset = 1'b1;
    run(30);
    check("post_reset_no_alarm", 32'(outs), 32'(O_IDLE));
    timer_done = 1'b0;
    step();
    timer_done = 1'b1;
    step();
    check("post_reset_fresh_edge", 32'(outs), 32'(O_BEEP_LO));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
